// File: rtl/bit_stream_serializer_pkg.sv
// Shared definitions for the bit-stream serializer and its pacing counter.
package bit_stream_serializer_pkg;

  // Serializer state encoding.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Line level while no word is shifting. The detector bench idles at this same level.
  localparam logic SER_IDLE_LEVEL = 1'b1;

  // Counter width for a count range of n values, never below one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_stream_serializer_tick.sv
// Pacing counter: marks the last of DIV clocks spent on each serial bit.
// With DIV=1 the counter never leaves zero, so tick simply follows en.
module bit_tick_gen
  import bit_stream_serializer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  // Tick on the final subcycle; wrap, restart or park at zero when idle.
  always_comb begin
    tick      = en && (div_cnt_q == LAST);
    div_cnt_d = div_cnt_q + 1'b1;
    if (restart || !en || tick) begin
      div_cnt_d = '0;
    end
  end

  // Subcycle counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial source feeding the sequence detector's serial input.
// A new word may be accepted on the last subcycle of the current word, so
// consecutive words leave the block as one unbroken bit stream.
module bit_stream_serializer
  import bit_stream_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   DIV        = 1,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic tick;
  logic last_sub;
  logic accept;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == SER_SHIFT),
    .restart (accept),
    .tick    (tick)
  );

  // Handshake: ready while idle, or on the final subcycle of the final bit.
  always_comb begin
    last_sub   = (state_q == SER_SHIFT) && (bit_cnt_q == LAST_BIT) && tick;
    load_ready = (state_q == SER_IDLE) || last_sub;
    accept     = load_valid && load_ready;
  end

  // Next state: capture a word, advance a bit, or drop back to idle.
  // shreg holds only the bits not yet presented, so sout_q is the live bit.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sout_d       = sout_q;
    frame_done_d = last_sub;
    if (accept) begin
      state_d   = SER_SHIFT;
      bit_cnt_d = '0;
      if (MSB_FIRST) begin
        sout_d  = load_data[WIDTH-1];
        shreg_d = load_data << 1;
      end else begin
        sout_d  = load_data[0];
        shreg_d = load_data >> 1;
      end
    end else if (last_sub) begin
      state_d   = SER_IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      sout_d    = IDLE_LEVEL;
    end else if ((state_q == SER_SHIFT) && tick) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (MSB_FIRST) begin
        sout_d  = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end else begin
        sout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
    end
    sout_valid_d = (state_d == SER_SHIFT);
    busy_d       = (state_d == SER_SHIFT);
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SER_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: a default instance (DIV=1, MSB first)
// and a paced instance (DIV=3, LSB first) sharing clock and reset.
module tb_bit_stream_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_lv = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_rdy, a_sout, a_vld, a_busy, a_done;
  logic       b_lv = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_rdy, b_sout, b_vld, b_busy, b_done;

  bit_stream_serializer u_a (
    .clk        (clk),
    .rst        (rst),
    .load_valid (a_lv),
    .load_data  (a_data),
    .load_ready (a_rdy),
    .sout       (a_sout),
    .sout_valid (a_vld),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  bit_stream_serializer #(
    .WIDTH     (8),
    .DIV       (3),
    .MSB_FIRST (1'b0)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .load_valid (b_lv),
    .load_data  (b_data),
    .load_ready (b_rdy),
    .sout       (b_sout),
    .sout_valid (b_vld),
    .busy       (b_busy),
    .frame_done (b_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       lv;
    logic [7:0] data;
    logic       sout;
    logic       vld;
    logic       busy;
    logic       rdy;
    logic       done;
  } vec_t;

  vec_t tbl [19];

  task automatic set_row(input int i, input logic lv, input logic [7:0] d,
                         input logic so, input logic v, input logic b,
                         input logic r, input logic dn);
    tbl[i].lv   = lv;
    tbl[i].data = d;
    tbl[i].sout = so;
    tbl[i].vld  = v;
    tbl[i].busy = b;
    tbl[i].rdy  = r;
    tbl[i].done = dn;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, ".sout"}, 32'(a_sout), 32'd1);
    chk({tag, ".vld"},  32'(a_vld),  32'd0);
    chk({tag, ".busy"}, 32'(a_busy), 32'd0);
    chk({tag, ".rdy"},  32'(a_rdy),  32'd1);
    chk({tag, ".done"}, 32'(a_done), 32'd0);
  endtask

  // One isolated word on instance a; load_data is scrambled after acceptance.
  task automatic a_word(input logic [7:0] w, input string tag);
    @(negedge clk);
    a_lv   = 1'b1;
    a_data = w;
    chk({tag, ".rdy0"}, 32'(a_rdy), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      a_lv   = 1'b0;
      a_data = 8'($urandom);
      chk($sformatf("%s.sout%0d", tag, c), 32'(a_sout), 32'(w[8-c]));
      chk($sformatf("%s.vld%0d", tag, c),  32'(a_vld),  32'd1);
      chk($sformatf("%s.rdy%0d", tag, c),  32'(a_rdy),  32'(c == 8));
      chk($sformatf("%s.done%0d", tag, c), 32'(a_done), 32'd0);
    end
    @(negedge clk);
    chk({tag, ".done9"}, 32'(a_done), 32'd1);
    chk({tag, ".sout9"}, 32'(a_sout), 32'd1);
    chk({tag, ".vld9"},  32'(a_vld),  32'd0);
    chk({tag, ".busy9"}, 32'(a_busy), 32'd0);
    chk({tag, ".rdy9"},  32'(a_rdy),  32'd1);
    @(negedge clk);
    chk({tag, ".done10"}, 32'(a_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] stream;
    logic [3:0]  hist;
    int          hits;
    int          gaps;

    // Back-to-back A5 then 3C: producer holds load_valid throughout.
    set_row(0,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    set_row(1,  1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(2,  1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(3,  1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(4,  1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(5,  1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(6,  1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(7,  1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(8,  1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    set_row(9,  1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    set_row(10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(13, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(14, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(15, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_row(16, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    set_row(17, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    set_row(18, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset held for five cycles.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_a_idle($sformatf("rst%0d", i));
      chk($sformatf("rst%0d.b_vld", i), 32'(b_vld), 32'd0);
      chk($sformatf("rst%0d.b_sout", i), 32'(b_sout), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_a_idle("post_rst");

    // Single word A5, MSB first, DIV=1.
    a_word(8'hA5, "single_a5");

    // Gapless back-to-back words from the table.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      a_lv   = tbl[i].lv;
      a_data = tbl[i].data;
      chk($sformatf("b2b[%0d].sout", i), 32'(a_sout), 32'(tbl[i].sout));
      chk($sformatf("b2b[%0d].vld", i),  32'(a_vld),  32'(tbl[i].vld));
      chk($sformatf("b2b[%0d].busy", i), 32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("b2b[%0d].rdy", i),  32'(a_rdy),  32'(tbl[i].rdy));
      chk($sformatf("b2b[%0d].done", i), 32'(a_done), 32'(tbl[i].done));
    end

    // Pacing: DIV=3, LSB first, word 01 -> three 1s then twenty-one 0s.
    @(negedge clk);
    b_lv   = 1'b1;
    b_data = 8'h01;
    chk("div3.rdy0", 32'(b_rdy), 32'd1);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      b_lv   = 1'b0;
      b_data = 8'hFF;
      chk($sformatf("div3.sout%0d", c), 32'(b_sout), 32'(c <= 3));
      chk($sformatf("div3.vld%0d", c),  32'(b_vld),  32'd1);
      chk($sformatf("div3.rdy%0d", c),  32'(b_rdy),  32'(c == 24));
      chk($sformatf("div3.done%0d", c), 32'(b_done), 32'd0);
    end
    @(negedge clk);
    chk("div3.done25", 32'(b_done), 32'd1);
    chk("div3.vld25",  32'(b_vld),  32'd0);
    chk("div3.sout25", 32'(b_sout), 32'd1);
    @(negedge clk);
    chk("div3.done26", 32'(b_done), 32'd0);

    // Abort: asynchronous reset mid-cycle after four bits of FF.
    @(negedge clk);
    a_lv   = 1'b1;
    a_data = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      a_lv = 1'b0;
      chk($sformatf("abort.vld%0d", c), 32'(a_vld), 32'd1);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_a_idle("abort.async");
    @(negedge clk);
    chk_a_idle("abort.held");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_a_idle("abort.released");
    a_word(8'h0F, "after_abort_0f");

    // Integration: two back-to-back B4 words through a 1011 Moore detector model.
    stream = '0;
    hist   = '0;
    hits   = 0;
    gaps   = 0;
    @(negedge clk);
    a_lv   = 1'b1;
    a_data = 8'b1011_0100;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 9) a_lv = 1'b0;
      if (!a_vld) gaps++;
      stream = {stream[14:0], a_sout};
      hist   = {hist[2:0], a_sout};
      if (c >= 4 && hist == 4'b1011) hits++;
    end
    chk("integ.stream", 32'(stream), 32'h0000_B4B4);
    chk("integ.gaps",   32'(gaps),   32'd0);
    chk("integ.hits",   32'(hits),   32'd2);
    @(negedge clk);
    chk("integ.done", 32'(a_done), 32'd1);
    chk("integ.idle", 32'(a_vld),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-to-serial source that converts WIDTH-bit words into a single-bit stream, one bit per pacing period.
- Sits directly upstream of the Moore sequence detector and drives its serial `inp` input.
- Producer-side valid/ready handshake allows gapless back-to-back words, so detector patterns can span word boundaries.

Parameters:
- WIDTH, 8, bits per word; legal when >=2.
- DIV, 1, clocks each bit is held on sout; legal when >=1.
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first, 0 = emit bit 0 first.
- IDLE_LEVEL, 1, sout value when no word is being shifted.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset (0 = reset).
- load_valid, input, 1, producer has a word on load_data.
- load_data, input, WIDTH, word to serialize.
- load_ready, output, 1, block accepts a word this cycle.
- sout, output, 1, serial bit; connects to the detector's inp.
- sout_valid, output, 1, sout carries a data bit.
- busy, output, 1, a word is in flight.
- frame_done, output, 1, one-cycle pulse after a word's last bit completes.

Behaviour:
- Reset (rst=0, asynchronous)
  - state=IDLE; sout=IDLE_LEVEL; sout_valid=0; busy=0; frame_done=0.
  - Shift register, bit counter and div counter cleared.
  - load_ready=1 once rst releases.
  - Reset mid-frame aborts the word immediately; its remaining bits are never emitted.
- States: IDLE, SHIFT.
- IDLE
  - load_ready=1.
  - Accept occurs when load_valid && load_ready at a clock edge: capture load_data, bit_cnt=0, div_cnt=0, go to SHIFT.
- Latency: first bit appears on sout in the cycle after acceptance. sout, sout_valid and busy are all registered.
- SHIFT
  - sout = current bit; sout_valid=1; busy=1.
  - Each bit is held exactly DIV cycles.
  - div_cnt counts 0..DIV-1; bit advances when div_cnt==DIV-1.
  - bit_cnt counts 0..WIDTH-1.
- Last-subcycle condition: bit_cnt==WIDTH-1 && div_cnt==DIV-1.
  - load_ready=1 in this cycle only (combinational from state and counters); load_ready=0 in every other SHIFT cycle.
  - If load_valid=1: capture the new word and stay in SHIFT, counters reset to 0. The new word's first bit follows with no idle gap.
  - Else: go to IDLE; sout=IDLE_LEVEL, sout_valid=0, busy=0 from the next cycle.
- frame_done
  - Pulses high for one cycle: the cycle after each word's last subcycle.
  - Fires in both the back-to-back and the return-to-IDLE case.
- load_valid while load_ready=0: ignored; no capture. The producer must hold load_valid and load_data.
- load_data changes while not accepted: no effect on sout.
- Counter widths: $clog2(WIDTH) and $clog2(DIV), minimum 1 bit each.
- Shift direction
  - MSB_FIRST=1: shift left, output the top bit.
  - MSB_FIRST=0: shift right, output bit 0.
- No X propagation: all registers are reset.

Decomposition:
- Shared package holds:
  - state encoding localparams: SER_IDLE=1'b0, SER_SHIFT=1'b1;
  - default IDLE_LEVEL constant (1'b1), shared with the detector bench's idle input level.
- One sub-module: bit_tick_gen.
  - DIV-cycle pacing counter with enable and restart.
  - Produces a tick on the last subcycle of each bit.
  - When DIV=1 it degenerates to a constant tick.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release. Required: sout=1, sout_valid=0, busy=0, load_ready=1, frame_done=0 throughout. Assert rst=0 asynchronously mid-cycle: outputs return to reset values before the next edge.
- Single word, DIV=1, MSB_FIRST=1, load 8'hA5:
  - sout = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept;
  - frame_done=1 on cycle 9;
  - sout=1, sout_valid=0, load_ready=1 from cycle 9.
- Back-to-back, load_valid held with 8'hA5 then 8'h3C:
  - 16 contiguous valid bits 10100101 00111100 with no gap;
  - load_ready high only on cycle 8;
  - frame_done on cycles 9 and 17.
- Pacing, DIV=3, MSB_FIRST=0, load 8'h01:
  - sout=1 for 3 cycles, then 0 for 21 cycles;
  - frame_done on cycle 25.
- Abort: pull rst low after 4 bits of 8'hFF. Required: sout=1 (idle), sout_valid=0 immediately. After release, loading 8'h0F serializes correctly from bit 0 of the new frame.
- Integration: serialize 8'b10110100 into the Moore detector's inp. Required: the detector output matches its golden model for the same serial sequence, with no glitch at word boundaries.
